fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that produces the instruction and PC+2 stream consumed by the fetch-to-decode pipeline register. It owns the PC, runs a single-outstanding request/response handshake to instruction memory, absorbs downstream stalls with a one-entry skid buffer, and handles redirects from execute and halt detection. Its outputs feed the pipeline register's instruction/PC+2 inputs. When no valid instruction is available, the outputs present the NOP encoding.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset
- NOP_INSTR, 16'h0800, encoding driven when no valid instruction
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- imem_req  output  1  request strobe; one-cycle pulse per fetch
- imem_addr  output  16  fetch address; valid when imem_req=1
- imem_done  input  1  response strobe; imem_rdata valid this cycle; at least 1 cycle after its imem_req
- imem_rdata  input  16  fetched instruction
- id_stall  input  1  downstream holding; output register must not change except on redirect
- redirect  input  1  taken branch/jump; flush and refetch
- redirect_pc  input  16  target; valid when redirect=1
- outInstruct  output  16  instruction to pipeline register
- outPlusTwoPC  output  16  fetch PC + 2 for outInstruct
- out_valid  output  1  outInstruct is a real fetched instruction
- halted  output  1  HALT (opcode 5'b00000) fetched; fetching stopped
- err  output  1  sticky; odd redirect_pc received

## Operation
- States: FETCH (issue request), WAIT (request outstanding), HOLD (response parked in skid buffer), DRAIN (outstanding response to discard), STOP (halted or err).
- FETCH: imem_req=1, imem_addr=pc; go WAIT. pc advances by 2 on the response accept, not on issue.
- WAIT, imem_done=1, id_stall=0: load output register with {rdata, pc+2, valid=1}; pc←pc+2. Next state is STOP if rdata[15:11]=5'b00000; otherwise FETCH.
- WAIT, imem_done=1, id_stall=1: park {rdata, pc+2} in skid buffer; go HOLD. The output register holds.
- HOLD: when id_stall falls, move skid buffer to output register; pc←pc+2. Then apply the same HALT check and go FETCH or STOP.
- Output register when id_stall=0 and nothing is loaded: {NOP_INSTR, pc_of_last_load, valid=0}. outPlusTwoPC holds its value.
- redirect (highest priority, any state, ignores id_stall):
  - Output register←{NOP_INSTR, unchanged, 0}.
  - Skid buffer is cleared.
  - pc←redirect_pc.
  - If in WAIT and imem_done=0, go DRAIN; otherwise go FETCH.
  - redirect_pc[0]=1 sets err and goes STOP.
- DRAIN: wait for imem_done, discard the data, go FETCH. A second redirect in DRAIN only updates pc.
- STOP: no requests. halted=1 if entered by HALT. A redirect with an even target leaves STOP (clearing halted) for FETCH or DRAIN. err is cleared only by reset.
- imem_done in FETCH, HOLD, or STOP is a protocol error: it is ignored and causes no state change.

## Timing
- Reset (async assert): pc=RESET_PC, state=FETCH, outInstruct=NOP_INSTR, outPlusTwoPC=0, out_valid=0, halted=0, err=0, skid empty.
- First imem_req is high in the first cycle after rst deasserts, with addr=RESET_PC.
- Reset mid-transaction abandons the outstanding request. imem_done in the first post-reset cycle is accepted as the response to the new FETCH only after that FETCH is issued; a response arriving earlier is ignored.
- Latency: response accepted at edge E gives valid outputs from E onward, i.e. registered one cycle after imem_done.
- Throughput: with 1-cycle memory, one instruction per 2 cycles; out_valid=0 in gap cycles.
- Redirect and imem_done in the same WAIT cycle: the response is dropped; next state is FETCH at redirect_pc.
- Redirect and id_stall in the same cycle: the flush wins.
- PC arithmetic is modulo 2^16: pc 16'hFFFE gives outPlusTwoPC 16'h0000 and the next fetch at 16'h0000.

## Test plan
- Reset, 1-cycle memory returning 16'hC001 at 0x0000 → imem_req at addr 0; outInstruct=C001, outPlusTwoPC=0002, out_valid=1; next req addr 0x0002.
- id_stall high before a response at addr 0x0004, held 3 cycles → outputs unchanged for 3 cycles, state HOLD; after release, the parked instruction appears with outPlusTwoPC=0006, and no request is issued during HOLD.
- 3-cycle memory with redirect to 0x0100 one cycle after req → late response discarded; next imem_req addr=0x0100; out_valid=0 until that response.
- Redirect coincident with imem_done and id_stall=1 → outInstruct=0800, out_valid=0; next req at the target.
- Fetch 16'h0000 at 0x0010 → out_valid=1 with outPlusTwoPC=0012, halted=1, no further imem_req; a later redirect to 0x0020 clears halted and resumes fetching.
- Redirect to 0x0033 → err=1, no requests. Separately, PC 0xFFFE → outPlusTwoPC=0000 and the next fetch at 0x0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to instruction
// memory, parks a response in a one-entry skid buffer while decode stalls.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_done,
  input  logic [15:0] imem_rdata,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] outInstruct,
  output logic [15:0] outPlusTwoPC,
  output logic        out_valid,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] out_instr_q, out_instr_d;
  logic [15:0] out_pc2_q, out_pc2_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] skid_instr_q, skid_instr_d;
  logic [15:0] skid_pc2_q, skid_pc2_d;
  logic        outstanding_q, outstanding_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;

  logic [15:0] pc_plus2;
  logic        load_en;
  logic [15:0] load_instr;
  logic [15:0] load_pc2;

  assign pc_plus2 = pc_q + 16'd2;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    out_instr_d   = out_instr_q;
    out_pc2_d     = out_pc2_q;
    out_valid_d   = out_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc2_d    = skid_pc2_q;
    outstanding_d = outstanding_q;
    halted_d      = halted_q;
    err_d         = err_q;
    imem_req      = 1'b0;
    imem_addr     = pc_q;
    load_en       = 1'b0;
    load_instr    = imem_rdata;
    load_pc2      = pc_plus2;

    // With decode free and nothing new arriving, the output register shows a bubble.
    if (!id_stall) begin
      out_instr_d = NOP_INSTR;
      out_valid_d = 1'b0;
    end

    if (redirect) begin
      out_instr_d   = NOP_INSTR;
      out_valid_d   = 1'b0;
      skid_instr_d  = NOP_INSTR;
      skid_pc2_d    = 16'h0000;
      pc_d          = redirect_pc;
      halted_d      = 1'b0;
      outstanding_d = outstanding_q && !imem_done;
      if (redirect_pc[0]) begin
        err_d   = 1'b1;
        state_d = S_STOP;
      end else if (outstanding_q && !imem_done) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          imem_req      = 1'b1;
          outstanding_d = 1'b1;
          state_d       = S_WAIT;
        end
        S_WAIT: begin
          if (imem_done) begin
            outstanding_d = 1'b0;
            if (id_stall) begin
              skid_instr_d = imem_rdata;
              skid_pc2_d   = pc_plus2;
              state_d      = S_HOLD;
            end else begin
              load_en = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (!id_stall) begin
            load_en      = 1'b1;
            load_instr   = skid_instr_q;
            load_pc2     = skid_pc2_q;
            skid_instr_d = NOP_INSTR;
            skid_pc2_d   = 16'h0000;
          end
        end
        S_DRAIN: begin
          if (imem_done) begin
            outstanding_d = 1'b0;
            state_d       = S_FETCH;
          end
        end
        S_STOP: begin
          // Only a response still owed from before an error stop is absorbed here.
          if (imem_done) outstanding_d = 1'b0;
        end
        default: state_d = S_FETCH;
      endcase

      if (load_en) begin
        out_instr_d = load_instr;
        out_pc2_d   = load_pc2;
        out_valid_d = 1'b1;
        pc_d        = pc_plus2;
        if (load_instr[15:11] == 5'b00000) begin
          halted_d = 1'b1;
          state_d  = S_STOP;
        end else begin
          state_d = S_FETCH;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      out_instr_q   <= NOP_INSTR;
      out_pc2_q     <= 16'h0000;
      out_valid_q   <= 1'b0;
      skid_instr_q  <= NOP_INSTR;
      skid_pc2_q    <= 16'h0000;
      outstanding_q <= 1'b0;
      halted_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_instr_q   <= out_instr_d;
      out_pc2_q     <= out_pc2_d;
      out_valid_q   <= out_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc2_q    <= skid_pc2_d;
      outstanding_q <= outstanding_d;
      halted_q      <= halted_d;
      err_q         <= err_d;
    end
  end

  assign outInstruct  = out_instr_q;
  assign outPlusTwoPC = out_pc2_q;
  assign out_valid    = out_valid_q;
  assign halted       = halted_q;
  assign err          = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed cycle table, a reset-abandon sequence, then a
// randomized run against a transaction-level model of the expected fetch stream.
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_done;
  logic [15:0] imem_rdata;
  logic        id_stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] outInstruct;
  logic [15:0] outPlusTwoPC;
  logic        out_valid;
  logic        halted;
  logic        err;

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_done   (imem_done),
    .imem_rdata  (imem_rdata),
    .id_stall    (id_stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .outInstruct (outInstruct),
    .outPlusTwoPC(outPlusTwoPC),
    .out_valid   (out_valid),
    .halted      (halted),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rd;
    logic [15:0] rd_pc;
    logic        done;
    logic [15:0] rdata;
    logic        req;
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        vld;
    logic        hlt;
    logic        er;
  } vec_t;

  vec_t tbl[32];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  // Memory contents: bit 11 forced high so random code never contains HALT.
  function automatic logic [15:0] mem(input logic [15:0] a);
    logic [15:0] m;
    m = a * 16'h9E37;
    return (m ^ 16'h5A5A) | 16'h0800;
  endfunction

  task automatic idle_inputs();
    id_stall    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    imem_done   = 1'b0;
    imem_rdata  = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    id_stall    = v.stall;
    redirect    = v.rd;
    redirect_pc = v.rd_pc;
    imem_done   = v.done;
    imem_rdata  = v.rdata;
    #1;
    chk($sformatf("v%0d_req", idx), 16'(imem_req), 16'(v.req));
    if (v.req) chk($sformatf("v%0d_addr", idx), imem_addr, v.addr);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_instr", idx), outInstruct, v.instr);
    chk($sformatf("v%0d_pc2", idx), outPlusTwoPC, v.pc2);
    chk($sformatf("v%0d_valid", idx), 16'(out_valid), 16'(v.vld));
    chk($sformatf("v%0d_halted", idx), 16'(halted), 16'(v.hlt));
    chk($sformatf("v%0d_err", idx), 16'(err), 16'(v.er));
    @(negedge clk);
  endtask

  logic [15:0] exp_pc;
  logic [15:0] prev_instr, prev_pc2;
  logic        prev_vld;
  logic        pend;
  int          cnt;
  logic [15:0] pend_addr;
  int          loads;

  initial begin
    //            stall rd rd_pc     done rdata     req addr      instr     pc2       v  h  e
    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, NOP,      16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hC001, 1'b0, 16'h0000, 16'hC001, 16'h0002, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0002, NOP,      16'h0002, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h0000, 16'h1234, 16'h0004, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h1234, 16'h0004, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h5678, 1'b0, 16'h0000, 16'h1234, 16'h0004, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h1234, 16'h0004, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h1234, 16'h0004, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h5678, 16'h0006, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0006, NOP,      16'h0006, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 16'h0000, NOP,      16'h0006, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, NOP,      16'h0006, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h9999, 1'b0, 16'h0000, NOP,      16'h0006, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0100, NOP,      16'h0006, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h4321, 1'b0, 16'h0000, 16'h4321, 16'h0102, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0102, 16'h4321, 16'h0102, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 16'h0010, 1'b1, 16'h7777, 1'b0, 16'h0000, NOP,      16'h0102, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0010, NOP,      16'h0102, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0012, 1'b1, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, NOP,      16'h0012, 1'b0, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, NOP,      16'h0012, 1'b0, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000, 1'b0, 16'h0000, NOP,      16'h0012, 1'b0, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0020, NOP,      16'h0012, 1'b0, 1'b0, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hABCD, 1'b0, 16'h0000, 16'hABCD, 16'h0022, 1'b1, 1'b0, 1'b0};
    tbl[24] = '{1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 1'b0, 16'h0000, NOP,      16'h0022, 1'b0, 1'b0, 1'b0};
    tbl[25] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hFFFE, NOP,      16'h0022, 1'b0, 1'b0, 1'b0};
    tbl[26] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b0, 16'h0000, 16'h2222, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[27] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, NOP,      16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[28] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h3333, 1'b0, 16'h0000, 16'h3333, 16'h0002, 1'b1, 1'b0, 1'b0};
    tbl[29] = '{1'b0, 1'b1, 16'h0033, 1'b0, 16'h0000, 1'b0, 16'h0000, NOP,      16'h0002, 1'b0, 1'b0, 1'b1};
    tbl[30] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, NOP,      16'h0002, 1'b0, 1'b0, 1'b1};
    tbl[31] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, NOP,      16'h0002, 1'b0, 1'b0, 1'b1};

    rst = 1'b0;
    idle_inputs();
    #12;
    chk("rst_instr", outInstruct, NOP);
    chk("rst_pc2", outPlusTwoPC, 16'h0000);
    chk("rst_valid", 16'(out_valid), 16'h0);
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 32; i++) run_vec(tbl[i], i);

    // Async reset mid-cycle clears the sticky error without a clock edge.
    rst = 1'b0;
    #1;
    chk("arst_err", 16'(err), 16'h0);
    chk("arst_req", 16'(imem_req), 16'h1);
    @(negedge clk);
    rst = 1'b1;
    run_vec('{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, NOP, 16'h0000, 1'b0, 1'b0, 1'b0}, 100);
    // Request outstanding in WAIT; reset abandons it and a stale response in the
    // first post-reset cycle must be ignored.
    rst = 1'b0;
    #1;
    chk("mid_rst_req", 16'(imem_req), 16'h1);
    chk("mid_rst_addr", imem_addr, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    run_vec('{1'b0, 1'b0, 16'h0000, 1'b1, 16'hDEAD, 1'b1, 16'h0000, NOP, 16'h0000, 1'b0, 1'b0, 1'b0}, 101);
    run_vec('{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111, 1'b0, 16'h0000, 16'h1111, 16'h0002, 1'b1, 1'b0, 1'b0}, 102);

    // Randomized run: memory with 1..3 cycle latency, random stalls and even redirects.
    do_reset();
    exp_pc = 16'h0000;
    pend   = 1'b0;
    cnt    = 0;
    pend_addr = 16'h0000;
    loads  = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      prev_instr = outInstruct;
      prev_pc2   = outPlusTwoPC;
      prev_vld   = out_valid;
      imem_done  = 1'b0;
      imem_rdata = 16'($urandom);
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_done  = 1'b1;
          imem_rdata = mem(pend_addr);
          pend       = 1'b0;
        end
      end
      id_stall    = ($urandom_range(0, 9) < 3);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 16'($urandom) & 16'hFFFE;
      #1;
      if (imem_req) begin
        chk($sformatf("r%0d_addr", cyc), imem_addr, exp_pc);
        chk($sformatf("r%0d_req_busy", cyc), 16'(pend), 16'h0);
        pend      = 1'b1;
        cnt       = $urandom_range(1, 3);
        pend_addr = imem_addr;
      end
      @(posedge clk);
      #1;
      if (redirect) begin
        chk($sformatf("r%0d_flush_v", cyc), 16'(out_valid), 16'h0);
        chk($sformatf("r%0d_flush_i", cyc), outInstruct, NOP);
        chk($sformatf("r%0d_flush_p", cyc), outPlusTwoPC, prev_pc2);
        exp_pc = redirect_pc;
      end else if (id_stall) begin
        chk($sformatf("r%0d_hold_i", cyc), outInstruct, prev_instr);
        chk($sformatf("r%0d_hold_p", cyc), outPlusTwoPC, prev_pc2);
        chk($sformatf("r%0d_hold_v", cyc), 16'(out_valid), 16'(prev_vld));
      end else if (out_valid) begin
        chk($sformatf("r%0d_load_i", cyc), outInstruct, mem(exp_pc));
        chk($sformatf("r%0d_load_p", cyc), outPlusTwoPC, exp_pc + 16'd2);
        exp_pc = exp_pc + 16'd2;
        loads++;
      end else begin
        chk($sformatf("r%0d_idle_i", cyc), outInstruct, NOP);
        chk($sformatf("r%0d_idle_p", cyc), outPlusTwoPC, prev_pc2);
      end
    end
    total++;
    if (loads < 200) begin
      bad++;
      $display("FAIL progress: got %0d loads want at least 200", loads);
    end else begin
      $display("ok   progress: %0d loads", loads);
    end
    total++;
    if (halted !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL rand_flags: got halted=%b err=%b want 0 0", halted, err);
    end else begin
      $display("ok   rand_flags");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
